// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART transmitter.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned IDX_W     = 3;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                res = 32'(i + 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, reloads on restart, flags the last cycle of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 16
) (
    input  logic clkin,
    input  logic rst_n,
    input  logic restart,
    output logic bit_end,
    output logic bit_pre_end_c
);

    localparam int unsigned CNT_W = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

    logic [CNT_W-1:0] r_cnt;
    logic             r_bit_end;

    // Free-running bit counter; a restart aligns the first bit of a frame to the accept edge.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_end <= 1'b0;
        end else begin
            if (restart || (r_cnt == CNT_LAST)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_bit_end <= !restart && (r_cnt == CNT_PRE);
        end
    end

    assign bit_end       = r_bit_end;
    assign bit_pre_end_c = (r_cnt == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional parity, one or two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clkin,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
    localparam logic        PAR_INV   = (PARITY == PARITY_ODD);
    localparam logic [IDX_W-1:0] IDX_LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST_STOP = IDX_W'(STOP_BITS - 1);

    // Reject parameter combinations the framing cannot support.
    if (DIV < 2) begin : g_bad_div
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   w_shift_next;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [IDX_W-1:0]       w_bit_idx_next;
    logic                   r_par;
    logic                   w_par_next;
    logic                   r_tx;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_tx_next;
    logic                   w_done_next;
    logic                   w_accept;
    logic                   w_bit_end;
    logic                   w_pre_end;
    logic                   w_last_stop;

    assign w_accept    = tx_valid && r_ready;
    assign w_last_stop = (r_bit_idx == IDX_LAST_STOP);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clkin         (clkin),
        .rst_n         (rst_n),
        .restart       (w_accept),
        .bit_end       (w_bit_end),
        .bit_pre_end_c (w_pre_end)
    );

    // State register.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: each non-idle state advances on the end of its bit period.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_START;
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_idx == IDX_LAST_DATA)) begin
                    w_state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end && w_last_stop) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are looked ahead one cycle so they can be registered.
    always_comb begin
        w_shift_next   = r_shift;
        w_bit_idx_next = r_bit_idx;
        w_par_next     = r_par;
        w_tx_next      = 1'b1;
        w_done_next    = 1'b0;

        if (w_accept) begin
            w_shift_next   = tx_data;
            w_bit_idx_next = '0;
            w_par_next     = 1'b0;
        end else if (w_bit_end) begin
            if (r_state == ST_DATA) begin
                w_shift_next   = r_shift >> 1;
                w_par_next     = r_par ^ r_shift[0];
                w_bit_idx_next = (r_bit_idx == IDX_LAST_DATA) ? '0 : r_bit_idx + IDX_W'(1);
            end else if (r_state == ST_STOP) begin
                w_bit_idx_next = w_last_stop ? '0 : r_bit_idx + IDX_W'(1);
            end
        end

        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_par_next ^ PAR_INV;
            default:   w_tx_next = 1'b1;
        endcase

        // Pre-end of the last stop bit means the next cycle is the final cycle of the frame.
        w_done_next = (r_state == ST_STOP) && w_last_stop && w_pre_end;
    end

    // Datapath and output registers.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_shift   <= w_shift_next;
            r_bit_idx <= w_bit_idx_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_ready   <= (w_state_next == ST_IDLE);
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_ready;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx across several parameter sets.
module tb_uart_tx;

    localparam int CLK_PERIOD = 10;

    logic       clk = 1'b0;
    logic       rst_n [5];
    logic [7:0] data  [5];
    logic       valid [5];
    logic       ready [5];
    logic       txl   [5];
    logic       busy  [5];
    logic       done  [5];

    int checks   = 0;
    int failures = 0;

    always #(CLK_PERIOD / 2) clk = ~clk;

    // 0: P=none S=1   1: P=even S=1   2: P=odd S=1   3: P=even S=2   4: defaults
    uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .clkin(clk), .rst_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(ready[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(1)) u_e1 (
        .clkin(clk), .rst_n(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(ready[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(2), .STOP_BITS(1)) u_o1 (
        .clkin(clk), .rst_n(rst_n[2]), .tx_data(data[2]), .tx_valid(valid[2]),
        .tx_ready(ready[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    uart_tx #(.CLK_FREQ(1600), .BAUD_RATE(100), .PARITY(1), .STOP_BITS(2)) u_e2 (
        .clkin(clk), .rst_n(rst_n[3]), .tx_data(data[3]), .tx_valid(valid[3]),
        .tx_ready(ready[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));
    uart_tx u_def (
        .clkin(clk), .rst_n(rst_n[4]), .tx_data(data[4]), .tx_valid(valid[4]),
        .tx_ready(ready[4]), .tx(txl[4]), .tx_busy(busy[4]), .tx_done(done[4]));

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [11:0] exp;   // bit i = i-th serial bit on the line
        int          nb;
        int          div;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Send one byte and check every cycle of the resulting frame plus the first idle cycle.
    task automatic run_frame(input int s, input logic [7:0] b, input logic [7:0] b_mid,
                             input logic [11:0] exp, input int nb, input int div,
                             input bit keep, input bit hold, input string tag,
                             output time t_acc);
        int   len;
        int   waited;
        int   done_cnt;
        int   done_at;
        bit   ready_bad;
        bit   busy_bad;
        logic obs [12];
        len       = nb * div;
        waited    = 0;
        done_cnt  = 0;
        done_at   = -1;
        ready_bad = 0;
        busy_bad  = 0;
        t_acc     = 0;
        for (int k = 0; k < 12; k++) obs[k] = exp[k];
        while (ready[s] !== 1'b1 && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready_wait"}, 32'(ready[s]), 32'd1);
        if (ready[s] !== 1'b1) return;
        data[s]  = b;
        valid[s] = 1'b1;
        @(posedge clk);
        t_acc = $time;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) valid[s] = 1'b0;
            if (keep && c == 3 * div) data[s] = b_mid;
            if (c == len + 1 && keep && !hold) valid[s] = 1'b0;
            if (c <= len) begin
                if (txl[s] !== exp[(c - 1) / div]) obs[(c - 1) / div] = txl[s];
                if (ready[s] !== 1'b0) ready_bad = 1;
            end else begin
                if (ready[s] !== 1'b1) ready_bad = 1;
            end
            if (busy[s] !== !ready[s]) busy_bad = 1;
            if (done[s] === 1'b1) begin
                done_cnt++;
                done_at = c;
            end
        end
        for (int k = 0; k < nb; k++)
            check($sformatf("%s_bit%0d", tag, k), 32'(obs[k]), 32'(exp[k]));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_cycle"}, 32'(done_at), 32'(len));
        check({tag, "_ready_profile_bad"}, 32'(ready_bad), 32'd0);
        check({tag, "_busy_not_ready_bad"}, 32'(busy_bad), 32'd0);
    endtask

    initial begin
        time t1;
        time t2;
        int  dcnt;
        bit  tx_low_seen;

        vecs[0] = '{0, 8'h55, 12'h2AA, 10, 16};
        vecs[1] = '{1, 8'h07, 12'h60E, 11, 16};
        vecs[2] = '{2, 8'h07, 12'h40E, 11, 16};
        vecs[3] = '{0, 8'hFF, 12'h3FE, 10, 16};
        vecs[4] = '{1, 8'hD3, 12'h7A6, 11, 16};
        vecs[5] = '{2, 8'h80, 12'h500, 11, 16};
        vecs[6] = '{3, 8'h00, 12'hC00, 12, 16};
        vecs[7] = '{4, 8'h00, 12'h200, 10, 868};

        for (int i = 0; i < 5; i++) begin
            rst_n[i] = 1'b1;
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end
        #1;
        for (int i = 0; i < 5; i++) rst_n[i] = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("reset_tx%0d", i),    32'(txl[i]),   32'd1);
            check($sformatf("reset_ready%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("reset_busy%0d", i),  32'(busy[i]),  32'd0);
            check($sformatf("reset_done%0d", i),  32'(done[i]),  32'd0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) rst_n[i] = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_frame(vecs[i].sel, vecs[i].data, 8'h00, vecs[i].exp, vecs[i].nb, vecs[i].div,
                      1'b0, 1'b0, $sformatf("vec%0d", i), t1);

        // tx_data changed mid-frame with tx_valid held: frame unaffected, no early re-accept.
        run_frame(0, 8'h55, 8'hAA, 12'h2AA, 10, 16, 1'b1, 1'b0, "midchg", t1);
        repeat (3) @(negedge clk);
        check("midchg_no_reaccept_ready", 32'(ready[0]), 32'd1);

        // Back-to-back frames with tx_valid held high, two stop bits plus parity.
        run_frame(3, 8'hA5, 8'h3C, 12'hD4A, 12, 16, 1'b1, 1'b1, "b2b_a5", t1);
        run_frame(3, 8'h3C, 8'h00, 12'hC78, 12, 16, 1'b0, 1'b0, "b2b_3c", t2);
        check("b2b_spacing", 32'((t2 - t1) / CLK_PERIOD), 32'd193);

        // Reset in the middle of data bit 4, then a clean frame afterwards.
        @(negedge clk);
        data[0]  = 8'h00;
        valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[0] = 1'b0;
        repeat (86) @(negedge clk);
        check("pre_reset_tx_low", 32'(txl[0]), 32'd0);
        #1 rst_n[0] = 1'b0;
        #1;
        check("midreset_tx",    32'(txl[0]),   32'd1);
        check("midreset_ready", 32'(ready[0]), 32'd1);
        check("midreset_busy",  32'(busy[0]),  32'd0);
        check("midreset_done",  32'(done[0]),  32'd0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        dcnt = 0;
        tx_low_seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done[0] === 1'b1) dcnt++;
            if (txl[0] !== 1'b1) tx_low_seen = 1;
        end
        check("postreset_no_done", 32'(dcnt), 32'd0);
        check("postreset_idle_high_bad", 32'(tx_low_seen), 32'd0);
        run_frame(0, 8'hFF, 8'h00, 12'h3FE, 10, 16, 1'b0, 1'b0, "after_reset", t1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000; clkin frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200; serial bit rate in bit/s.
REQ-003 Parameter PARITY, default 0; 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1; legal values 1 or 2.
REQ-005 clkin  input  1; single clock, all logic on its rising edge.
REQ-006 rst_n  input  1; asynchronous, active-low reset.
REQ-007 tx_data  input  8; byte to transmit, sampled only on an accept.
REQ-008 tx_valid  input  1; upstream holds a byte for transmission.
REQ-009 tx_ready  output  1; block is able to accept a byte this cycle.
REQ-010 tx  output  1; serial line, idle high, registered.
REQ-011 tx_busy  output  1; frame in progress, equal to the inverse of tx_ready.
REQ-012 tx_done  output  1; single-cycle pulse marking frame completion.

Function
REQ-013 Bit period DIV SHALL be CLK_FREQ/BAUD_RATE (integer truncation); every serial bit SHALL last exactly DIV clkin cycles.
REQ-014 Bit-period counter width SHALL be clog2(DIV); the counter SHALL count 0..DIV-1, wrap to 0, and reload to 0 on every frame start.
REQ-015 Elaboration SHALL fail if DIV < 2, PARITY is not in {0,1,2}, or STOP_BITS is not in {1,2}.
REQ-016 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 Accept SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a shift register at that edge.
REQ-018 tx_ready SHALL be 1 only in IDLE; tx_data and tx_valid outside IDLE SHALL be ignored.
REQ-019 Accept SHALL move IDLE to START; tx SHALL go low in the first cycle after the accept edge (latency 1).
REQ-020 START SHALL output 0 for DIV cycles, then move to DATA.
REQ-021 DATA SHALL output 8 bits, LSB first, each lasting DIV cycles.
REQ-022 DATA SHALL move to PARITY if PARITY != 0, else to STOP.
REQ-023 PARITY SHALL output the XOR of the 8 data bits (even) or its inverse (odd) for DIV cycles.
REQ-024 STOP SHALL output 1 for STOP_BITS*DIV cycles, then move to IDLE.
REQ-025 tx_done SHALL pulse high in the final cycle of STOP; tx_ready SHALL assert in the next cycle.
REQ-026 With tx_valid held high, the spacing between successive start-bit falling edges SHALL be (9 + (PARITY!=0) + STOP_BITS)*DIV + 1 cycles.
REQ-027 tx SHALL be high in every cycle spent in IDLE.
REQ-028 A byte presented in the cycle tx_done is high SHALL NOT be accepted until tx_ready is 1.

Reset
REQ-029 rst_n low SHALL immediately force tx=1, tx_ready=1, tx_busy=0, tx_done=0, state IDLE, all counters 0, and shift register 0.
REQ-030 Reset mid-frame SHALL abandon the frame without completing it; after release, the first accept SHALL start a complete new frame.

Structure
REQ-031 Shared package uart_pkg SHALL hold the state encoding, the PARITY constants (NONE/EVEN/ODD), and the clog2 function.
REQ-032 Sub-module uart_baud_gen SHALL hold the bit-period counter and produce a one-cycle bit_end strobe; it has inputs clkin, rst_n, and restart.
REQ-033 The FSM, shift register, bit index (3 bits), and parity accumulator SHALL reside in uart_tx.

Verification (CLK_FREQ=1600, BAUD_RATE=100, DIV=16 unless stated)
REQ-034 Accept 0x55, PARITY=0, STOP_BITS=1 -> tx: 0,1,0,1,0,1,0,1,0,1 at 16 cycles each; tx_done at cycle 160 after the accept; tx_ready at cycle 161.
REQ-035 Accept 0x07 with PARITY=1, then again with PARITY=2 -> parity bit 1 (even), then 0 (odd); frame length 176 cycles.
REQ-036 STOP_BITS=2, tx_valid held high, bytes 0xA5 then 0x3C -> falling edges 193 cycles apart; both bytes decode correctly.
REQ-037 tx_data changed mid-frame while tx_valid=1 -> transmitted bits unaffected; no second accept before tx_ready=1.
REQ-038 rst_n pulsed low during DATA bit 4 -> tx=1 within the same cycle; no tx_done; next accept of 0xFF yields a clean frame.
REQ-039 Default parameters, accept 0x00 -> start bit lasts 868 cycles; total frame 8680 cycles.
